// File: rtl/rr_excl_arbiter_if.sv
// rtl/rr_excl_arbiter_if.sv - request/grant bundle between requesters and the exclusive-resource arbiter
interface rr_excl_arbiter_if #(
  parameter int N = 4
) ();
  localparam int IDW = $clog2(N);

  logic [N-1:0]   req;
  logic           done;
  logic [N-1:0]   gnt;
  logic [IDW-1:0] gnt_id;
  logic           busy;
  logic           timeout;

  // Requester side drives requests and release; arbiter side drives the grant.
  modport master (
    output req, done,
    input  gnt, gnt_id, busy, timeout
  );

  modport slave (
    input  req, done,
    output gnt, gnt_id, busy, timeout
  );
endinterface

// File: rtl/rr_excl_arbiter.sv
// rtl/rr_excl_arbiter.sv - round-robin arbiter for one exclusive resource with dead cycle and hold limit
module rr_excl_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst,
  rr_excl_arbiter_if.slave bus
);
  localparam int IDW = $clog2(N);
  localparam int CW  = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t         state;
  logic [IDW-1:0] ptr;
  logic [CW-1:0]  cnt;
  logic [N-1:0]   gnt_q;
  logic [IDW-1:0] id_q;
  logic           busy_q;
  logic           to_q;

  logic           found;
  logic [IDW-1:0] win;
  logic [IDW-1:0] win_next;
  logic [IDW:0]   scan;
  logic [IDW:0]   nsum;
  logic           release_now;

  // Find the first requesting bit at or above ptr, wrapping past N-1 back to 0.
  always_comb begin
    found = 1'b0;
    win   = '0;
    scan  = '0;
    for (int k = 0; k < N; k++) begin
      scan = {1'b0, ptr} + (IDW+1)'(k);
      if (scan >= (IDW+1)'(N)) scan = scan - (IDW+1)'(N);
      if (!found && bus.req[scan[IDW-1:0]]) begin
        found = 1'b1;
        win   = scan[IDW-1:0];
      end
    end
    nsum = {1'b0, win} + (IDW+1)'(1);
    if (nsum >= (IDW+1)'(N)) nsum = '0;
    win_next = nsum[IDW-1:0];
  end

  // Owner lets go voluntarily or stops requesting; wins over the hold limit.
  always_comb begin
    release_now = bus.done || !bus.req[id_q];
  end

  // Arbitration FSM; every output is a register so nothing reaches the pins combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      ptr    <= '0;
      cnt    <= '0;
      gnt_q  <= '0;
      id_q   <= '0;
      busy_q <= 1'b0;
      to_q   <= 1'b0;
    end else begin
      case (state)
        IDLE, GAP: begin
          to_q <= 1'b0;
          if (found) begin
            state  <= GRANT;
            gnt_q  <= N'(1) << win;
            id_q   <= win;
            busy_q <= 1'b1;
            cnt    <= CW'(1);
            ptr    <= win_next;
          end else begin
            state  <= IDLE;
            gnt_q  <= '0;
            id_q   <= '0;
            busy_q <= 1'b0;
            cnt    <= '0;
          end
        end
        GRANT: begin
          if (release_now || cnt == CW'(MAX_HOLD)) begin
            state  <= GAP;
            gnt_q  <= '0;
            id_q   <= '0;
            busy_q <= 1'b0;
            cnt    <= '0;
            to_q   <= !release_now;
          end else begin
            cnt  <= cnt + CW'(1);
            to_q <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          gnt_q  <= '0;
          id_q   <= '0;
          busy_q <= 1'b0;
          cnt    <= '0;
          to_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.gnt_id  = id_q;
  assign bus.busy    = busy_q;
  assign bus.timeout = to_q;

  // Mutual exclusion and handover invariants.
  a_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_q));
  a_busy:   assert property (@(posedge clk) disable iff (rst) busy_q == (|gnt_q));
  a_handover: assert property (@(posedge clk) disable iff (rst)
    (($past(gnt_q) != '0) && (gnt_q != '0)) |-> (gnt_q == $past(gnt_q)));
  a_to_pulse: assert property (@(posedge clk) disable iff (rst) !(to_q && $past(to_q)));
  a_gnt_req: assert property (@(posedge clk) disable iff (rst)
    ((gnt_q != '0) && ($past(gnt_q) == '0)) |-> ((gnt_q & $past(bus.req)) == gnt_q));
endmodule

// File: tb/tb_rr_excl_arbiter.sv
// tb/tb_rr_excl_arbiter.sv - randomized and directed checks of rr_excl_arbiter against a behavioural model
module tb_rr_excl_arbiter;
  localparam int N        = 4;
  localparam int MAX_HOLD = 8;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  // Reference model: who owns the resource, for how long, where the search starts.
  int m_owner;
  int m_hold;
  int m_ptr;
  bit m_to;

  rr_excl_arbiter_if #(.N(N)) bus ();

  rr_excl_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_hold  = 0;
    m_ptr   = 0;
    m_to    = 0;
  endtask

  // One clock edge of the arbitration rules.
  task automatic model_edge(input logic [N-1:0] r, input logic d);
    if (m_owner >= 0) begin
      if (d || !r[m_owner]) begin
        m_owner = -1;
        m_to    = 0;
      end else if (m_hold == MAX_HOLD) begin
        m_owner = -1;
        m_to    = 1;
      end else begin
        m_hold++;
        m_to = 0;
      end
    end else begin
      m_to = 0;
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (r[c]) begin
          m_owner = c;
          m_hold  = 1;
          m_ptr   = (c + 1) % N;
          break;
        end
      end
    end
  endtask

  task automatic cyc(input string tag);
    logic [N-1:0] exp_gnt;
    @(posedge clk);
    model_edge(bus.req, bus.done);
    #1;
    exp_gnt = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    check({tag, ".gnt"}, 32'(bus.gnt), 32'(exp_gnt));
    check({tag, ".gnt_id"}, 32'(bus.gnt_id), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
    check({tag, ".busy"}, 32'(bus.busy), 32'(m_owner >= 0));
    check({tag, ".timeout"}, 32'(bus.timeout), 32'(m_to));
    check({tag, ".onehot"}, 32'($onehot0(bus.gnt)), 32'd1);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    bus.req  = '0;
    bus.done = 1'b0;
    @(posedge clk);
    #1;
    check("rst.gnt", 32'(bus.gnt), 32'd0);
    check("rst.gnt_id", 32'(bus.gnt_id), 32'd0);
    check("rst.busy", 32'(bus.busy), 32'd0);
    check("rst.timeout", 32'(bus.timeout), 32'd0);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int n;
    logic [N-1:0] seq[$];
    rst      = 1'b1;
    bus.req  = '0;
    bus.done = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    do_reset();

    // Single requester: one-edge latency.
    bus.req = 4'b0100;
    cyc("single");
    check("single.gnt_exp", 32'(bus.gnt), 32'h4);
    check("single.id_exp", 32'(bus.gnt_id), 32'd2);
    bus.req = '0;
    repeat (3) cyc("single_rel");

    // Two requesters alternating, each released after two held cycles.
    do_reset();
    bus.req = 4'b1001;
    for (int i = 0; i < 14; i++) begin
      bus.done = (m_owner >= 0 && m_hold == 2);
      cyc("rr");
      if (bus.gnt != '0 && (seq.size() == 0 || seq[$] != bus.gnt)) seq.push_back(bus.gnt);
    end
    bus.done = 1'b0;
    check("rr.count", 32'(seq.size() >= 3), 32'd1);
    if (seq.size() >= 3) begin
      check("rr.first", 32'(seq[0]), 32'h1);
      check("rr.second", 32'(seq[1]), 32'h8);
      check("rr.third", 32'(seq[2]), 32'h1);
    end

    // Forced release with another requester waiting.
    do_reset();
    bus.req = 4'b0011;
    cyc("to_wait");
    n = 0;
    while (bus.gnt == 4'b0001 && n < 20) begin
      n++;
      cyc("to_wait");
    end
    check("to_wait.hold", 32'(n), 32'd8);
    check("to_wait.pulse", 32'(bus.timeout), 32'd1);
    cyc("to_wait");
    check("to_wait.next", 32'(bus.gnt), 32'h2);

    // Forced release with the same requester alone: re-granted after the gap.
    do_reset();
    bus.req = 4'b0010;
    cyc("to_sole");
    n = 0;
    while (bus.gnt == 4'b0010 && n < 20) begin
      n++;
      cyc("to_sole");
    end
    check("to_sole.hold", 32'(n), 32'd8);
    check("to_sole.pulse", 32'(bus.timeout), 32'd1);
    cyc("to_sole");
    check("to_sole.regrant", 32'(bus.gnt), 32'h2);

    // done on the last allowed cycle: plain release, no timeout.
    do_reset();
    bus.req = 4'b0001;
    cyc("lim");
    repeat (7) cyc("lim");
    bus.done = 1'b1;
    cyc("lim");
    check("lim.gnt", 32'(bus.gnt), 32'd0);
    check("lim.timeout", 32'(bus.timeout), 32'd0);
    bus.done = 1'b0;

    // Asynchronous reset while owned, then pointer restarts at 0.
    do_reset();
    bus.req = 4'b0100;
    cyc("arst");
    #2 rst = 1'b1;
    #1;
    check("arst.gnt", 32'(bus.gnt), 32'd0);
    check("arst.busy", 32'(bus.busy), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    bus.req = 4'b1111;
    cyc("arst_after");
    check("arst_after.gnt", 32'(bus.gnt), 32'h1);

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) bus.req = N'($urandom);
      bus.done = ($urandom_range(0, 4) == 0);
      cyc("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rr_excl_arbiter.md
Name: rr_excl_arbiter

Overview:
- Round-robin arbiter that shares one exclusive resource among N requesters.
- Guarantees the grant vector is one-hot or zero on every cycle, so no two owners are ever active together.
- Inserts one dead cycle between owners and forces release after MAX_HOLD cycles.
- Sits in front of any shared datapath whose enables must be mutually exclusive.

Parameters:
- N, 4, number of requesters (2..16).
- MAX_HOLD, 8, maximum consecutive cycles one owner keeps the grant (>=1).
- IDW, $clog2(N), width of the owner index (derived, not overridden).

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- req  input  N  per-requester request, level-sensitive.
- done  input  1  current owner releases the resource; sampled only in GRANT.
- gnt  output  N  registered grant, one-hot or zero.
- gnt_id  output  IDW  index of the current owner; 0 when gnt==0.
- busy  output  1  high whenever gnt!=0.
- timeout  output  1  one-cycle pulse when a forced release occurs.

Behaviour:
- Reset (asynchronous, immediate on rst=1):
  - gnt=0, gnt_id=0, busy=0, timeout=0.
  - State=IDLE, priority pointer ptr=0, hold counter cnt=0.
- Reset mid-grant drops gnt in the same cycle, without waiting for a clock edge.
- States: IDLE, GRANT, GAP.
- IDLE:
  - If any req bit is set at an edge, the winner is the first set bit found searching upward from ptr, wrapping.
  - At that edge gnt=onehot(winner), gnt_id=winner, cnt=1, ptr=(winner+1) mod N, state goes to GRANT.
  - Latency from req high to gnt high is one edge.
  - If req==0, stay in IDLE.
- GRANT:
  - Release condition: done=1, or req[gnt_id]=0.
  - On release at an edge: gnt=0, gnt_id=0, state goes to GAP, timeout=0.
  - Otherwise, if cnt==MAX_HOLD: forced release. gnt=0, state goes to GAP, timeout=1 for exactly one cycle.
  - Otherwise cnt increments.
  - A normal release takes precedence over a timeout on the same edge: no timeout pulse.
  - req changes on non-owner bits are ignored while in GRANT.
- GAP:
  - gnt=0 for exactly one cycle (the dead cycle).
  - At the next edge, arbitrate exactly as in IDLE.
  - If there is a winner, go to GRANT; otherwise go to IDLE.
  - timeout returns to 0.
- Fairness:
  - ptr always points one past the last owner, including after a forced release.
  - A timed-out requester that still requests goes behind every other active requester.
  - It is re-granted after GAP only if it is the sole requester.
- Counter:
  - cnt width is $clog2(MAX_HOLD+1).
  - cnt never exceeds MAX_HOLD and is cleared to 0 in IDLE/GAP.
- Invariants, to be carried as concurrent assertions in the block, disabled during rst:
  - $onehot0(gnt).
  - busy == |gnt.
  - gnt never changes directly from one nonzero value to a different one.
  - timeout never high for two consecutive cycles.
  - gnt[i] implies req[i] was high at the granting edge.
- done while not in GRANT is ignored.
- All outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
- Reset then req=4'b0100: gnt=4'b0100, gnt_id=2, busy=1 one edge later; ptr becomes 3.
- Two-requester round-robin:
  - Stimulus: req=4'b1001 held, done pulsed each time an owner has held the grant for 2 cycles.
  - Required response: gnt=0001, then 0 for the 1-cycle gap, then 1000, then 0, then 0001 again.
  - No cycle ever has two gnt bits high.
- Timeout with a waiting requester:
  - Stimulus: req=4'b0011 held, done=0.
  - Required response: gnt=0001 for exactly 8 cycles, then timeout=1 for one cycle with gnt=0, then gnt=0010.
- Timeout, sole requester: req=4'b0010 held, done=0 -> gnt high 8 cycles, gap 1 cycle with timeout=1, then gnt=0010 re-granted.
- Simultaneous release and limit: owner asserts done on the 8th held cycle -> gnt clears, timeout stays 0.
- Reset mid-operation: rst asserted asynchronously while gnt=0100 -> gnt=0, busy=0 immediately. After rst deassert, req=1111 -> gnt=0001 (ptr reset to 0).
